mem_stage_wb: RTL

- MEM stage of the 5-stage MIPS32 pipeline; consumes the EX/MEM pipeline register outputs.
- Owns the data memory and resolves branch/jump redirects for the fetch PC mux.
- Holds the MEM/WB pipeline register that feeds the write-back mux and the register file.
- Counts taken redirects for debug.

---
 rtl/mips_pkg.sv | 17 +
 rtl/data_mem_sp.sv | 26 ++
 rtl/mem_stage_wb.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: alignment constants,
// memory sizing defaults and the MEM/WB bundle used by WB.
package mips_pkg;

    localparam int WORD_ALIGN_BITS = 2;
    localparam int DM_WORDS_DEF    = 256;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misaligned;
    } mem_wb_t;

endpackage

// File: rtl/data_mem_sp.sv
// Single-port word RAM: combinational read, synchronous write.
// Contents are deliberately not reset.
module data_mem_sp #(
    parameter int WORDS = 256,
    parameter int DW    = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read sees pre-edge contents, so same-word write returns old data.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_wb.sv
// MIPS32 MEM stage: data memory, branch/jump redirect,
// MEM/WB pipeline register and saturating redirect counter.
module mem_stage_wb
    import mips_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_stall,
    input  logic             in_flush,
    input  logic [31:0]      in_branch_target,
    input  logic             in_zf,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_store_data,
    input  logic [4:0]       in_rd,
    input  logic             in_branch,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic             in_jump,
    input  logic [31:0]      in_jump_target,
    output logic             out_pc_src,
    output logic [31:0]      out_pc_target,
    output logic             out_redirect_flush,
    output logic [31:0]      out_mem_data,
    output logic [31:0]      out_alu_result,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_to_reg,
    output logic             out_misaligned,
    output logic [CNT_W-1:0] out_redirect_cnt
);

    localparam int AW = $clog2(DM_WORDS);

    logic             taken;
    logic             misaligned;
    logic             mem_we;
    logic [AW-1:0]    word_idx;
    logic [31:0]      ram_rdata;
    logic [31:0]      load_data;
    mem_wb_t          mem_wb_q, mem_wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign taken = ~in_flush & ((in_branch & in_zf) | in_jump);

    assign out_pc_src         = taken;
    assign out_redirect_flush = taken;
    assign out_pc_target      = in_jump ? in_jump_target : in_branch_target;

    // Upper address bits are dropped so accesses wrap within the RAM.
    assign word_idx   = in_alu_result[AW+WORD_ALIGN_BITS-1:WORD_ALIGN_BITS];
    assign misaligned = (in_mem_read | in_mem_write)
                      & (in_alu_result[WORD_ALIGN_BITS-1:0] != '0);
    assign mem_we     = in_mem_write & ~misaligned & ~in_stall & ~in_flush;
    assign load_data  = (in_mem_read & ~misaligned) ? ram_rdata : '0;

    data_mem_sp #(
        .WORDS (DM_WORDS),
        .DW    (32)
    ) u_dmem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (in_store_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (!in_stall) begin
            mem_wb_d.alu_result = in_alu_result;
            mem_wb_d.mem_data   = load_data;
            mem_wb_d.rd         = in_rd;
            mem_wb_d.mem_to_reg = in_mem_to_reg;
            // A flushed op or a faulting load must not retire a write.
            mem_wb_d.reg_write  = in_reg_write & ~in_flush
                                & ~(in_mem_read & misaligned);
            mem_wb_d.misaligned = misaligned & ~in_flush;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (taken && !in_stall && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_mem_data     = mem_wb_q.mem_data;
    assign out_alu_result   = mem_wb_q.alu_result;
    assign out_rd           = mem_wb_q.rd;
    assign out_reg_write    = mem_wb_q.reg_write;
    assign out_mem_to_reg   = mem_wb_q.mem_to_reg;
    assign out_misaligned   = mem_wb_q.misaligned;
    assign out_redirect_cnt = cnt_q;

endmodule
